rr_mux4_arbiter: RTL and testbench
==================================

# rr_mux4_arbiter

Round-robin arbiter that shares the n-bit 4-to-1 line multiplexer datapath among four requesters. Each requester presents its data word and a request line. The arbiter selects one owner at a time and drives the multiplexer select from registered state. The selected word appears on the shared output bus together with a one-hot grant and a valid flag. It sits between the requesting units and any consumer of the shared n-bit bus.

## Interface
- `N`, default 4: data width of each input word and of `Y`.
- `HOLD`, default 4: maximum consecutive grant cycles for one owner while others wait; legal range 1..255.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `REQ`  input  4  request lines; bit i corresponds to data input i (A=0, B=1, C=2, D=3).
- `A`, `B`, `C`, `D`  input  N each  requester data words.
- `GNT`  output  4  one-hot grant, registered; all zero when idle.
- `S`  output  2  registered multiplexer select, equal to the index of the current owner.
- `VALID`  output  1  registered; high while a grant is active.
- `Y`  output  N  `A`/`B`/`C`/`D` selected by `S` when `VALID`=1, otherwise all zero (combinational from registered `S`/`VALID`).

## Operation
- State machine has two states: IDLE and GRANT. Internal registers are owner index `S`, last-winner pointer `LAST` (2 bits), and hold counter `CNT` (8 bits).
- Round-robin pick: the winner is the first set bit of `REQ` scanning from index (LAST+1) mod 4 upward with wrap-around. `LAST` is updated to the winner on every new grant.
- IDLE:
  - `GNT`=0 and `VALID`=0.
  - If `REQ`≠0 at a clock edge, go to GRANT with the picked winner and `CNT`=0.
- GRANT, evaluated each edge, in priority order:
  1. `REQ[S]`=0 (owner releases): if any other `REQ` bit is set, grant the RR winner directly with `CNT`=0 and no idle cycle. Otherwise go to IDLE.
  2. Owner still requesting, `CNT`=HOLD-1, and another `REQ` bit set (only when the macro is enabled): rotate to the RR winner with `CNT`=0.
  3. Otherwise keep the owner. `CNT` increments and saturates at HOLD-1.
- A sole requester is never preempted. Its `CNT` saturates and its grant continues.
- Simultaneous release by the owner and a new request from another index on the same edge: the new request is granted on that edge, following rule 1.
- `REQ` bits for non-owners may toggle freely. Only their value at a clock edge matters.

## Timing
- Reset values: `GNT`=0000, `S`=00, `VALID`=0, `Y`=0, `LAST`=11, `CNT`=0, state IDLE. Reset takes effect immediately, mid-grant included, without waiting for a clock edge.
- Because `LAST`=11 after reset, requester 0 has first priority.
- Grant latency: `REQ` sampled high at edge k produces `GNT`/`S`/`VALID` updated after edge k, so data is on `Y` in the cycle following the request.
- Release latency: `REQ[S]` sampled low at edge k means the grant moves or drops after edge k.
- Handover between owners costs zero idle cycles.
- With the macro enabled and all four requesting continuously, each owner holds exactly HOLD cycles.

## Configuration
- `RR_HOLD_LIMIT_EN` defined: rule 2 is active, and an owner is preempted after HOLD consecutive cycles when any other requester is pending.
- Undefined: rule 2 is removed, `CNT` is unused, and an owner keeps the grant for as long as its `REQ` stays high. Arbitration happens only on release or from IDLE.

## Test plan
- Reset, then `REQ`=0001, A=0011 -> after the next edge: `GNT`=0001, `S`=00, `VALID`=1, `Y`=0011.
- Macro on, HOLD=4, `REQ`=1111 held, A..D=0011/0110/1100/1001 -> `GNT` runs 0001×4, 0010×4, 0100×4, 1000×4, 0001×4; `Y` follows the owner's word.
- Owner 1 granted, `REQ` changes 0110→0100 -> after the next edge: `GNT`=0100, `S`=10, `VALID` stays 1 (no gap). Then `REQ`=0000 -> `GNT`=0000, `VALID`=0, `Y`=0000.
- Macro off, `REQ`=0011 held for 20 cycles -> `GNT`=0001 for all 20 cycles. Then drop `REQ[0]` -> `GNT`=0010 after the next edge.
- Macro on, `REQ`=0100 alone for 10 cycles -> `GNT`=0100 continuously with no preemption.
- `rst` pulsed mid-grant while `GNT`=0100 -> `GNT`=0, `VALID`=0, `Y`=0 immediately, before any clock edge. After `rst` is released, `REQ`=1001 -> `GNT`=0001.

Source files
------------

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing a 4-to-1 n-bit mux among four requesters.
// Define RR_HOLD_LIMIT_EN to preempt an owner after HOLD cycles when others wait.
module rr_mux4_arbiter #(
    parameter int N    = 4,
    parameter int HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   REQ,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    output logic [3:0]   GNT,
    output logic [1:0]   S,
    output logic         VALID,
    output logic [N-1:0] Y
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("HOLD must be in 1..255");
    end

    state_t     r_state;
    state_t     w_state_nx;
    logic [1:0] r_s;
    logic [1:0] r_last;
    logic [3:0] r_gnt;
    logic       r_valid;

    logic [1:0] w_s_nx;
    logic [1:0] w_last_nx;
    logic [1:0] w_win;
    logic [1:0] w_idx;
    logic       w_found;
    logic       w_others;
    logic       w_new;

    // Scan from the slot after the last winner, wrapping at 4.
    always_comb begin
        w_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && REQ[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_others = |(REQ & ~(4'b0001 << r_s));

`ifdef RR_HOLD_LIMIT_EN
    localparam logic [7:0] LP_CNT_MAX = 8'(HOLD - 1);
    logic [7:0] r_cnt;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_last_nx  = r_last;
        w_new      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|REQ)
                    w_new = 1'b1;
            end
            ST_GRANT: begin
                if (!REQ[r_s]) begin
                    if (w_others)
                        w_new = 1'b1;
                    else
                        w_state_nx = ST_IDLE;
                end
`ifdef RR_HOLD_LIMIT_EN
                else if (r_cnt == LP_CNT_MAX && w_others)
                    w_new = 1'b1;
`endif
            end
            default: w_state_nx = ST_IDLE;
        endcase
        if (w_new) begin
            w_state_nx = ST_GRANT;
            w_s_nx     = w_win;
            w_last_nx  = w_win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_s     <= 2'b00;
            r_last  <= 2'b11;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_s     <= w_s_nx;
            r_last  <= w_last_nx;
            r_valid <= (w_state_nx == ST_GRANT);
            r_gnt   <= (w_state_nx == ST_GRANT) ? (4'b0001 << w_s_nx) : 4'b0000;
        end
    end

`ifdef RR_HOLD_LIMIT_EN
    // Saturating run length of the current owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (w_new)
            r_cnt <= '0;
        else if (r_state == ST_GRANT && r_cnt != LP_CNT_MAX)
            r_cnt <= r_cnt + 8'd1;
    end
`endif

    always_comb begin
        Y = '0;
        if (r_valid) begin
            case (r_s)
                2'd0:    Y = A;
                2'd1:    Y = B;
                2'd2:    Y = C;
                default: Y = D;
            endcase
        end
    end

    assign GNT   = r_gnt;
    assign S     = r_s;
    assign VALID = r_valid;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter with hand-computed expectations.
// Hold-limit sequences are selected by RR_HOLD_LIMIT_EN.
module tb_rr_mux4_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] REQ;
    logic [3:0] A, B, C, D;
    logic [3:0] GNT;
    logic [1:0] S;
    logic       VALID;
    logic [3:0] Y;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] words [4];

    rr_mux4_arbiter #(.N(4), .HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .REQ   (REQ),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .GNT   (GNT),
        .S     (S),
        .VALID (VALID),
        .Y     (Y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // own < 0 means idle; S is only checked while a grant is active.
    task automatic expect_own(input string tag, input int own);
        if (own < 0) begin
            check({tag, ".gnt"}, 32'(GNT), 32'h0);
            check({tag, ".valid"}, 32'(VALID), 32'h0);
            check({tag, ".y"}, 32'(Y), 32'h0);
        end else begin
            check({tag, ".gnt"}, 32'(GNT), 32'(1 << own));
            check({tag, ".s"}, 32'(S), 32'(own));
            check({tag, ".valid"}, 32'(VALID), 32'h1);
            check({tag, ".y"}, 32'(Y), 32'(words[own]));
        end
    endtask

    initial begin
        words[0] = 4'b0011;
        words[1] = 4'b0110;
        words[2] = 4'b1100;
        words[3] = 4'b1001;
        A = words[0];
        B = words[1];
        C = words[2];
        D = words[3];
        REQ = 4'b0000;
        rst = 1'b1;
        #3;
        check("rst.gnt", 32'(GNT), 32'h0);
        check("rst.s", 32'(S), 32'h0);
        check("rst.valid", 32'(VALID), 32'h0);
        check("rst.y", 32'(Y), 32'h0);
        step();
        rst = 1'b0;

        REQ = 4'b0001; step(); expect_own("first", 0);
        REQ = 4'b0010; step(); expect_own("rel0to1", 1);
        REQ = 4'b0110; step(); expect_own("keep1", 1);
        REQ = 4'b0100; step(); expect_own("hand1to2", 2);
        REQ = 4'b0000; step(); expect_own("drop", -1);

`ifdef RR_HOLD_LIMIT_EN
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        REQ = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            step();
            expect_own($sformatf("rot%0d", i), (i / 4) % 4);
        end
`else
        REQ = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            step();
            expect_own($sformatf("nohold%0d", i), 0);
        end
        REQ = 4'b0010; step(); expect_own("rel0", 1);
`endif
        REQ = 4'b0000; step(); expect_own("idle2", -1);

        REQ = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_own($sformatf("sole%0d", i), 2);
        end

        REQ = 4'b1000; step(); expect_own("swap2to3", 3);
        REQ = 4'b0011; step(); expect_own("wrap3to0", 0);
        REQ = 4'b1010; step(); expect_own("rr0to1", 1);
        REQ = 4'b0100; step(); expect_own("to2", 2);

        #2 rst = 1'b1;
        #1;
        check("mid.gnt", 32'(GNT), 32'h0);
        check("mid.valid", 32'(VALID), 32'h0);
        check("mid.y", 32'(Y), 32'h0);
        check("mid.s", 32'(S), 32'h0);
        #2 rst = 1'b0;
        REQ = 4'b1001; step(); expect_own("postrst", 0);
        REQ = 4'b0000; step(); expect_own("end", -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
